// File: rtl/dda_ctrl_pkg.sv
// Shared constants and state encodings for the DDA command sequencer.
// Frame opcodes, reply codes and the main/transmit FSM state types.
package dda_ctrl_pkg;

  localparam int REG_SIZE = 10;
  localparam int OUT_SIZE = 4;
  localparam int TX_GUARD = 4;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_SNAP = 8'h53;
  localparam logic [7:0] ACK      = 8'h4C;
  localparam logic [7:0] NAK      = 8'h15;

  // ST_TX covers the whole reply; the per-byte handshake lives in tx_state_t
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARG,
    ST_RUN,
    ST_SNAP,
    ST_TX
  } ctrl_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_ISSUE,
    TX_HOLD,
    TX_DRAIN
  } tx_state_t;

endpackage

// File: rtl/dda_tx_byte.sv
// Single-byte UART transmit handshake: issue, wait for busy (4-cycle guard), drain.
// tx_start one cycle after i_req; o_done when tx_busy is low in drain, where the next req is also taken.
module dda_tx_byte
  import dda_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req,
  input  logic [7:0] i_dat,
  input  logic       i_tx_busy,
  output logic       o_tx_start,
  output logic [7:0] o_tx_byte,
  output logic       o_done
);

  tx_state_t  r_state;
  tx_state_t  w_next;
  logic [1:0] r_guard;
  logic [7:0] r_byte;
  logic       w_accept;

  assign w_accept   = (r_state == TX_IDLE) || ((r_state == TX_DRAIN) && !i_tx_busy);
  assign o_done     = (r_state == TX_DRAIN) && !i_tx_busy;
  assign o_tx_start = (r_state == TX_ISSUE);
  assign o_tx_byte  = r_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= TX_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      TX_IDLE:  if (i_req) w_next = TX_ISSUE;
      TX_ISSUE: w_next = TX_HOLD;
      // a UART that never raises busy must not hang the reply
      TX_HOLD:  if (i_tx_busy || (r_guard == 2'(TX_GUARD - 1))) w_next = TX_DRAIN;
      TX_DRAIN: if (!i_tx_busy) w_next = i_req ? TX_ISSUE : TX_IDLE;
      default:  w_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_guard <= '0;
      r_byte  <= '0;
    end else begin
      r_guard <= (r_state == TX_HOLD) ? r_guard + 2'd1 : 2'd0;
      if (i_req && w_accept) r_byte <= i_dat;
    end
  end

endmodule

// File: rtl/dda_seq_ctrl.sv
// Host command sequencer for the posit DDA: parses L/R/S frames, loads parameters,
// steps the integrator K times and replies with a tear-free 4-byte snapshot of v1/v2.
module dda_seq_ctrl
  import dda_ctrl_pkg::*;
#(
  parameter int N       = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_received,
  input  logic [7:0]   rx_byte,
  input  logic         rx_error,
  input  logic         tx_busy,
  output logic         tx_start,
  output logic [7:0]   tx_byte,
  input  logic [N-1:0] v1,
  input  logic [N-1:0] v2,
  output logic [N-1:0] ic1,
  output logic [N-1:0] ic2,
  output logic [N-1:0] vK_M,
  output logic [N-1:0] vD_M,
  output logic [N-1:0] dt,
  output logic         dda_load,
  output logic         dda_en,
  output logic         busy,
  output logic         ovr
);

  localparam int TW = $clog2(TIMEOUT);

  ctrl_state_t    r_state;
  ctrl_state_t    w_next;
  logic [7:0]     r_regs [REG_SIZE];
  logic [3:0]     r_idx;
  logic [7:0]     r_k_hi;
  logic [15:0]    r_cnt;
  logic [TW-1:0]  r_timer;
  logic [2*N-1:0] r_shadow;
  logic [1:0]     r_ridx;
  logic [1:0]     r_rlast;
  logic           r_ovr;
  logic           r_dda_load;

  logic           w_tx_req;
  logic [7:0]     w_tx_dat;
  logic           w_tx_done;
  logic           w_rx_ok;
  logic           w_timeout;
  logic           w_last_reg;
  logic [15:0]    w_k;

  function automatic logic [7:0] snap_sel(input logic [2*N-1:0] s, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = s[2*N-1 -: 8];
      2'd1:    b = s[N +: 8];
      2'd2:    b = s[N-1 -: 8];
      default: b = s[7:0];
    endcase
    return b;
  endfunction

  assign w_rx_ok    = rx_received && !rx_error;
  assign w_timeout  = (r_timer == TW'(TIMEOUT - 1));
  assign w_last_reg = (r_idx == 4'(REG_SIZE - 1));
  assign w_k        = {r_k_hi, rx_byte};

  assign ic1      = {r_regs[0], r_regs[1]};
  assign ic2      = {r_regs[2], r_regs[3]};
  assign vK_M     = {r_regs[4], r_regs[5]};
  assign vD_M     = {r_regs[6], r_regs[7]};
  assign dt       = {r_regs[8], r_regs[9]};
  assign dda_load = r_dda_load;
  assign dda_en   = (r_state == ST_RUN);
  assign busy     = (r_state != ST_IDLE);
  assign ovr      = r_ovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_tx_req = 1'b0;
    w_tx_dat = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (w_rx_ok) begin
          case (rx_byte)
            CMD_LOAD: w_next = ST_LOAD;
            CMD_RUN:  w_next = ST_ARG;
            CMD_SNAP: w_next = ST_SNAP;
            default: begin
              w_next   = ST_TX;
              w_tx_req = 1'b1;
              w_tx_dat = NAK;
            end
          endcase
        end
      end
      ST_LOAD: begin
        if (rx_error) begin
          w_next   = ST_TX;
          w_tx_req = 1'b1;
          w_tx_dat = NAK;
        end else if (rx_received) begin
          if (w_last_reg) begin
            w_next   = ST_TX;
            w_tx_req = 1'b1;
            w_tx_dat = ACK;
          end
        end else if (w_timeout) begin
          w_next = ST_IDLE;
        end
      end
      ST_ARG: begin
        if (rx_error) begin
          w_next   = ST_TX;
          w_tx_req = 1'b1;
          w_tx_dat = NAK;
        end else if (rx_received) begin
          if (r_idx == 4'd1) w_next = (w_k == 16'd0) ? ST_SNAP : ST_RUN;
        end else if (w_timeout) begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == 16'd1) w_next = ST_SNAP;
      end
      ST_SNAP: begin
        // shadow is being latched this cycle, so byte 0 comes straight from v1
        w_next   = ST_TX;
        w_tx_req = 1'b1;
        w_tx_dat = v1[N-1 -: 8];
      end
      ST_TX: begin
        if (w_tx_done) begin
          if (r_ridx == r_rlast) begin
            w_next = ST_IDLE;
          end else begin
            w_tx_req = 1'b1;
            w_tx_dat = snap_sel(r_shadow, r_ridx + 2'd1);
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_SIZE; i++) r_regs[i] <= '0;
      r_idx      <= '0;
      r_k_hi     <= '0;
      r_cnt      <= '0;
      r_timer    <= '0;
      r_shadow   <= '0;
      r_ridx     <= '0;
      r_rlast    <= '0;
      r_ovr      <= 1'b0;
      r_dda_load <= 1'b0;
    end else begin
      r_dda_load <= (r_state == ST_LOAD) && w_rx_ok && w_last_reg;

      if ((r_state == ST_IDLE) && w_rx_ok) begin
        r_ovr <= 1'b0;
      end else if (rx_received &&
                   ((r_state == ST_RUN) || (r_state == ST_SNAP) || (r_state == ST_TX))) begin
        r_ovr <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_idx   <= '0;
          r_timer <= '0;
        end
        ST_LOAD: begin
          if (w_rx_ok) begin
            r_regs[r_idx] <= rx_byte;
            r_idx         <= r_idx + 4'd1;
            r_timer       <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_ARG: begin
          if (w_rx_ok) begin
            if (r_idx == 4'd0) r_k_hi <= rx_byte;
            r_idx   <= r_idx + 4'd1;
            r_cnt   <= w_k;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RUN:  r_cnt <= r_cnt - 16'd1;
        ST_SNAP: r_shadow <= {v1, v2};
        default: ;
      endcase

      if (w_tx_req) begin
        if (r_state == ST_TX) begin
          r_ridx <= r_ridx + 2'd1;
        end else begin
          r_ridx  <= 2'd0;
          r_rlast <= (r_state == ST_SNAP) ? 2'(OUT_SIZE - 1) : 2'd0;
        end
      end
    end
  end

  dda_tx_byte u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (w_tx_req),
    .i_dat      (w_tx_dat),
    .i_tx_busy  (tx_busy),
    .o_tx_start (tx_start),
    .o_tx_byte  (tx_byte),
    .o_done     (w_tx_done)
  );

endmodule

// File: doc/dda_seq_ctrl.md
# dda_seq_ctrl

Command sequencer between the UART byte interface and the posit DDA integrator in `tt_um_dda`. Parses framed host commands, loads the parameter register file, steps the DDA a host-specified number of times, and streams a tear-free snapshot of the state variables back over UART. Replaces the free-running receive-10/send-4 loop with an explicit, abortable protocol.

## Interface
- N, 16, posit word width
- REG_SIZE, 10, parameter bytes per load frame
- OUT_SIZE, 4, state bytes per reply
- TIMEOUT, 50000, inter-byte idle cycles before a partial frame is aborted
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- rx_received  in  1  one-cycle pulse: rx_byte valid
- rx_byte  in  8  received byte
- rx_error  in  1  one-cycle pulse: framing error on current byte
- tx_busy  in  1  UART transmitter active
- tx_start  out  1  one-cycle transmit request
- tx_byte  out  8  byte to send; held stable from tx_start until tx_busy falls
- v1, v2  in  N  DDA state variables
- ic1, ic2, vK_M, vD_M, dt  out  N  parameters, big-endian from register bytes 0-1, 2-3, 4-5, 6-7, 8-9
- dda_load  out  1  one-cycle pulse: DDA reloads ic1/ic2
- dda_en  out  1  DDA step enable, one integration step per high cycle
- busy  out  1  high in any state other than IDLE
- ovr  out  1  sticky: byte dropped while not accepting

## Operation
- Commands, first byte of frame: 0x4C 'L' + 10 bytes; 0x52 'R' + 2-byte step count K, big-endian; 0x53 'S', no argument. Any other first byte -> reply 0x15 (NAK).
- States: IDLE, LOAD, ARG, RUN, SNAP, TX_ISSUE, TX_HOLD, TX_DRAIN.
- IDLE: the command byte selects LOAD, ARG, SNAP, or the NAK reply. Accepting a command byte clears ovr.
- LOAD: bytes are written to register index 0..9. After byte 9, pulse dda_load, then reply 0x4C (ACK).
- ARG: collect K. RUN: dda_en high for exactly K consecutive cycles, then SNAP. K=0 goes directly to SNAP.
- SNAP: latch {v1,v2} into a 32-bit shadow. Send shadow bytes v1[15:8], v1[7:0], v2[15:8], v2[7:0].
- Transmit per byte:
  - TX_ISSUE: pulse tx_start with tx_byte driven.
  - TX_HOLD: wait for tx_busy=1. If it is not seen within 4 cycles, proceed anyway.
  - TX_DRAIN: wait for tx_busy=0, then issue the next byte or return to IDLE.
- rx_error in LOAD or ARG: abort, send NAK, leave registers partially written. Bytes already written keep their new values.
- No rx_received for TIMEOUT cycles in LOAD or ARG: abort to IDLE with no reply.
- rx_received in RUN, SNAP or any TX state: byte dropped, ovr set.
- Reset: state IDLE; all registers, shadow and counters 0; all outputs 0 (ovr, busy, tx_start, tx_byte, dda_en, dda_load).

## Timing
- The register write is visible on the parameter outputs the cycle after the accepting rx_received. dda_load is asserted in that same cycle.
- The first dda_en cycle is the cycle after the last ARG byte is accepted.
- SNAP occurs the cycle after the last dda_en cycle, so v1/v2 reflect all K steps.
- tx_start rises the cycle after SNAP or after the ACK/NAK decision.
- Consecutive bytes are separated by at least one cycle after tx_busy falls.
- Async reset mid-RUN deasserts dda_en immediately. Mid-TX, tx_start drops and the partial reply is abandoned.
- K counter is 16 bits and does not wrap; K=0xFFFF gives exactly 65535 steps.

## Structure
- Shared package `dda_ctrl_pkg` holds:
  - state encoding
  - command constants CMD_LOAD=0x4C, CMD_RUN=0x52, CMD_SNAP=0x53
  - ACK=0x4C, NAK=0x15
  - REG_SIZE, OUT_SIZE
- Sub-module `dda_tx_byte`: owns TX_ISSUE/TX_HOLD/TX_DRAIN and the 4-cycle guard. It exposes a req/byte input and a done pulse to the main FSM.

## Test plan
- Send 4C 00 40 00 00 12 34 56 78 9A BC, then check:
  - ic1=0x0040, ic2=0x0000, vK_M=0x1234, vD_M=0x5678, dt=0x9ABC
  - one dda_load pulse
  - reply 0x4C
- Send 52 00 05 -> dda_en high exactly 5 consecutive cycles. Reply equals model {v1,v2} after 5 steps, in 4 bytes MSB first.
- Send 52 00 00 -> zero dda_en cycles; reply equals current state. Send 53 -> identical 4 bytes.
- Send 4C + 3 bytes then stall TIMEOUT cycles -> IDLE, no reply, busy=0. Then send 0x7E -> reply 0x15.
- Send bytes during RUN of K=100 -> ovr=1 and the run is unaffected. The next 0x53 command clears ovr.
- Assert rst_n low mid-reply (after byte 2) -> tx_start=0, dda_en=0, all parameter outputs 0 immediately. Then 0x53 after release -> full 4-byte reply.
